display_scanner: RTL and testbench

Front end of the reaction-timer display path. Accepts a binary reaction time in milliseconds and converts it to four BCD digits with a sequential double-dabble. It then time-multiplexes those digits onto the board display, producing the one-hot digit select consumed by the `SevenSeg` pin driver plus a coherent active-low segment pattern for the selected digit. Conversion and scanning run concurrently; the shown value changes atomically only when a conversion completes.

---
 rtl/display_scanner.sv | 158 +++++++++++++++
 tb/tb_display_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit multiplexed display scanner.
// Optional feature: define DISPLAY_LZB_EN to blank leading zeros on digits 3..1.
module display_scanner #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic [3:0]  digit_sel_o,
  output logic [6:0]  seg_o,
  output logic [1:0]  state_o
);

  localparam int DWELL = CLK_HZ / REFRESH_HZ;
  localparam int PW    = $clog2(DWELL);
  localparam logic [PW-1:0] LAST = PW'(DWELL - 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic [13:0]   r_bin;
  logic [15:0]   r_bcd;
  logic [3:0]    r_cnt;
  logic          r_pend_ovf;
  logic [15:0]   r_disp;
  logic          r_busy;
  logic          r_ovf;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_sel;
  logic [6:0]    r_seg;

  logic [15:0]   w_adj;
  logic          w_rot;
  logic          w_commit;
  logic [3:0]    w_sel_next;
  logic [15:0]   w_src;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = BLANK;
    endcase
  endfunction

  function automatic logic [1:0] f_idx(input logic [3:0] sel);
    case (sel)
      4'b0010: f_idx = 2'd1;
      4'b0100: f_idx = 2'd2;
      4'b1000: f_idx = 2'd3;
      default: f_idx = 2'd0;
    endcase
  endfunction

  // Pattern for digit idx of a BCD word; with blanking, a digit above the
  // ones place is dark when it and every higher nibble are zero.
  function automatic logic [6:0] f_pattern(input logic [15:0] bcd, input logic [1:0] idx);
    logic [15:0] shifted;
    shifted   = bcd >> {idx, 2'b00};
    f_pattern = f_decode(shifted[3:0]);
`ifdef DISPLAY_LZB_EN
    if (idx != 2'd0 && shifted == 16'd0) f_pattern = BLANK;
`endif
  endfunction

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign w_rot      = (r_presc == LAST);
  assign w_commit   = (r_state == S_COMMIT);
  assign w_sel_next = w_rot ? {r_sel[2:0], r_sel[3]} : r_sel;
  // On a commit edge the new value is still in r_bcd, not yet in r_disp.
  assign w_src      = w_commit ? r_bcd : r_disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend_ovf <= 1'b0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_i) begin
            if (value_i > 14'd9999) begin
              r_bin      <= 14'd9999;
              r_pend_ovf <= 1'b1;
            end else begin
              r_bin      <= value_i;
              r_pend_ovf <= 1'b0;
            end
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_bcd <= {w_adj[14:0], r_bin[13]};
          r_bin <= {r_bin[12:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd13) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_disp  <= r_bcd;
          r_ovf   <= r_pend_ovf;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_sel   <= 4'b0001;
      r_seg   <= BLANK;
    end else begin
      r_presc <= w_rot ? '0 : r_presc + PW'(1);
      r_sel   <= w_sel_next;
      if (w_rot || w_commit) r_seg <= f_pattern(w_src, f_idx(w_sel_next));
    end
  end

  assign busy_o      = r_busy;
  assign overflow_o  = r_ovf;
  assign digit_sel_o = r_sel;
  assign seg_o       = r_seg;
  assign state_o     = r_state;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with DWELL=4: vector table, hand-written corner sequences,
// and random loads checked every cycle against an arithmetic model of the display.
module tb_display_scanner;

  localparam int CLK_HZ     = 8;
  localparam int REFRESH_HZ = 2;
  localparam int DWELL      = CLK_HZ / REFRESH_HZ;
  localparam logic [6:0] BL = 7'b1111111;
`ifdef DISPLAY_LZB_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value_i = '0;
  logic        load_i = 1'b0;
  logic        busy_o;
  logic        overflow_o;
  logic [3:0]  digit_sel_o;
  logic [6:0]  seg_o;
  logic [1:0]  state_o;

  display_scanner #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ)) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i),
    .busy_o(busy_o), .overflow_o(overflow_o), .digit_sel_o(digit_sel_o),
    .seg_o(seg_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [13:0] exp_q[$];
  int          m_edges;
  int          m_cnt;
  int          m_shown;
  bit          m_ovf;
  int          m_dig;
  logic [6:0]  m_seg;

  logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] exp_seg(input int v, input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
`ifdef DISPLAY_LZB_EN
    if (d > 0 && v < p) return BL;
`endif
    return seg_lut[(v / p) % 10];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("busy", 32'(busy_o), 32'(m_cnt > 0));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("digit_sel", 32'(digit_sel_o), 32'(1 << m_dig));
    check("seg", 32'(seg_o), 32'(m_seg));
  endtask

  // driver: one clock edge with given load inputs, then model update and compare
  task automatic tick(input bit ld, input int val);
    bit rot, com;
    logic [13:0] v;
    load_i  = ld;
    value_i = 14'(val);
    @(posedge clk);
    m_edges++;
    com = (m_cnt == 1);
    if (m_cnt > 0) m_cnt--;
    else if (ld) begin
      m_cnt = 15;
      exp_q.push_back(14'(val));
    end
    if (com) begin
      v       = exp_q.pop_front();
      m_shown = (int'(v) > 9999) ? 9999 : int'(v);
      m_ovf   = (int'(v) > 9999);
    end
    rot = (m_edges % DWELL == 0);
    if (rot) m_dig = (m_dig + 1) % 4;
    if (rot || com) m_seg = exp_seg(m_shown, m_dig);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    load_i = 1'b0;
    @(posedge clk);
    exp_q.delete();
    m_edges = 0; m_cnt = 0; m_shown = 0; m_ovf = 0; m_dig = 0; m_seg = BL;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_sel", 32'(digit_sel_o), 32'b0001);
    check("rst_seg", 32'(seg_o), 32'(BL));
  endtask

  // scan until digit d is selected (bounded), then compare its pattern
  task automatic show_digit(input int d, input logic [6:0] exp, input string name);
    int n = 0;
    while (digit_sel_o != 4'(1 << d) && n < 2 * 4 * DWELL) begin
      tick(1'b0, 0);
      n++;
    end
    if (digit_sel_o != 4'(1 << d)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: digit %0d never selected, sel=%b", name, d, digit_sel_o);
    end else begin
      check(name, 32'(seg_o), 32'(exp));
    end
  endtask

  typedef struct {
    int          val;
    bit          ovf;
    logic [27:0] segs;  // {d3, d2, d1, d0}
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1234,  1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{10000, 1'b1, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
    vecs[2] = '{5,     1'b0, {LZ, LZ, LZ, 7'b0010010}};
    vecs[3] = '{7,     1'b0, {LZ, LZ, LZ, 7'b1111000}};
    vecs[4] = '{0,     1'b0, {LZ, LZ, LZ, 7'b1000000}};
    vecs[5] = '{9999,  1'b0, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
    vecs[6] = '{6021,  1'b0, {7'b0000010, 7'b1000000, 7'b0100100, 7'b1111001}};

    @(negedge clk);
    do_reset();

    // scan rotation timing from reset
    idle(3);
    check("sel_3edges", 32'(digit_sel_o), 32'b0001);
    idle(1);
    check("sel_4edges", 32'(digit_sel_o), 32'b0010);
    idle(12);
    check("sel_16edges", 32'(digit_sel_o), 32'b0001);

    // busy window for a load at edge k
    tick(1'b1, 1234);
    check("busy_k", 32'(busy_o), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0, 0);
      check($sformatf("busy_k+%0d", i), 32'(busy_o), 32'(i < 15));
    end

    // vector table
    for (int t = 0; t < 7; t++) begin
      tick(1'b1, vecs[t].val);
      idle(15);
      check($sformatf("vec%0d_ovf", t), 32'(overflow_o), 32'(vecs[t].ovf));
      for (int d = 0; d < 4; d++)
        show_digit(d, vecs[t].segs[d*7 +: 7], $sformatf("vec%0d_d%0d", t, d));
    end

    // second load while busy is dropped
    tick(1'b1, 42);
    idle(4);
    tick(1'b1, 99);
    idle(10);
    idle(20);
    show_digit(0, 7'b0100100, "ignored_load_d0");
    show_digit(1, 7'b0011001, "ignored_load_d1");

    // reset mid-conversion
    tick(1'b1, 42);
    idle(6);
    do_reset();
    idle(DWELL);
    check("post_rst_d1", 32'(seg_o), 32'(LZ));
    idle(20);

    // random loads against the model
    for (int i = 0; i < 700; i++) begin
      int v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 16383);
        1:       v = $urandom_range(9990, 10010);
        2:       v = $urandom_range(0, 99);
        default: v = $urandom_range(0, 9999);
      endcase
      tick($urandom_range(0, 5) == 0, v);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
